// File: rtl/mux_pkg.sv
// Shared constants for the mux_n_arb block: selection mode encodings and
// the transfer counter width.
package mux_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;
  localparam int   XFER_CNT_W = 16;
endpackage

// File: rtl/mux_n_arb_if.sv
// Stream bundle for mux_n_arb: N producer channels in, one consumer out.
// master = producer/consumer side, slave = the mux itself.
interface mux_n_arb_if #(
  parameter int WIDTH = 4,
  parameter int N     = 4
);
  localparam int SW = $clog2(N);

  logic [N-1:0][WIDTH-1:0] in_data;
  logic [N-1:0]            in_valid;
  logic [N-1:0]            in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [SW-1:0]           out_ch;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_ch
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );
endinterface

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin pick: first requester after ptr, wrapping mod N.
// The pointer register lives in the parent.
module rr_arbiter_n #(
  parameter  int N  = 4,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] grant,
  output logic          found
);
  int idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found = 1'b1;
        grant = SW'(idx);
      end
    end
  end
endmodule

// File: rtl/mux_n_arb.sv
// N-channel registered stream mux with fixed or round-robin selection.
// Optional MUX_N_ARB_CNT_EN adds a 16-bit output transfer counter.
module mux_n_arb
  import mux_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int N     = 4,
  localparam int SW    = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [SW-1:0]    sel,
  mux_n_arb_if.slave       bus
`ifdef MUX_N_ARB_CNT_EN
  ,
  output logic [XFER_CNT_W-1:0] xfer_cnt
`endif
);
  logic          load, accept, found, sel_ok;
  logic          rr_found;
  logic [SW-1:0] grant, rr_grant, ptr;

  rr_arbiter_n #(.N(N)) u_rr (
    .req   (bus.in_valid),
    .ptr   (ptr),
    .grant (rr_grant),
    .found (rr_found)
  );

  // sel can exceed N-1 when N is not a power of two; such a select never grants
  assign sel_ok = int'(sel) < N;

  always_comb begin
    grant = '0;
    found = 1'b0;
    if (mode == MODE_RR) begin
      grant = rr_grant;
      found = rr_found;
    end else begin
      grant = sel;
      found = sel_ok && bus.in_valid[sel];
    end
  end

  assign load   = !bus.out_valid || bus.out_ready;
  assign accept = load && found;

  always_comb begin
    bus.in_ready = '0;
    for (int i = 0; i < N; i++)
      bus.in_ready[i] = rst_n && accept && (grant == SW'(i));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
      ptr           <= SW'(N - 1);
    end else if (load) begin
      bus.out_valid <= found;
      if (found) begin
        bus.out_data <= bus.in_data[grant];
        bus.out_ch   <= grant;
        if (mode == MODE_RR) ptr <= grant;
      end
    end
  end

`ifdef MUX_N_ARB_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                            xfer_cnt <= '0;
    else if (bus.out_valid && bus.out_ready) xfer_cnt <= xfer_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_mux_n_arb.sv
// Scoreboard bench for mux_n_arb: directed stimulus pushes expected words,
// a negedge monitor pops them on every output handshake.
module tb_mux_n_arb;
  import mux_pkg::*;

  localparam int WIDTH = 4;
  localparam int N     = 4;

  typedef struct packed {
    logic [1:0] ch;
    logic [3:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode;
  logic [1:0] sel;
`ifdef MUX_N_ARB_CNT_EN
  logic [15:0] xfer_cnt;
`endif

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mux_n_arb_if #(.WIDTH(WIDTH), .N(N)) bus ();

  mux_n_arb #(.WIDTH(WIDTH), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  (mode),
    .sel   (sel),
    .bus   (bus)
`ifdef MUX_N_ARB_CNT_EN
    ,
    .xfer_cnt (xfer_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] ch, input logic [3:0] data);
    exp_t e;
    e.ch   = ch;
    e.data = data;
    q.push_back(e);
  endtask

  // monitor: every output handshake must match the next expected word
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got ch %0d data %0h, expected none",
                 bus.out_ch, bus.out_data);
      end else begin
        mon_e = q.pop_front();
        chk("out_ch", 32'(bus.out_ch), 32'(mon_e.ch));
        chk("out_data", 32'(bus.out_data), 32'(mon_e.data));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    mode          = MODE_FIXED;
    sel           = 2'd0;
    bus.in_data   = '0;
    bus.in_valid  = 4'hF;
    bus.out_ready = 1'b1;

    // reset with all channels valid
    step();
    step();
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_out_ch", 32'(bus.out_ch), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 0);
`ifdef MUX_N_ARB_CNT_EN
    chk("rst_xfer_cnt", 32'(xfer_cnt), 0);
`endif
    bus.in_valid = 4'h0;
    rst_n        = 1'b1;
    step();

    // fixed select of channel 2
    sel          = 2'd2;
    bus.in_data  = {4'h4, 4'hA, 4'h2, 4'h1};
    bus.in_valid = 4'hF;
    #1;
    chk("fix_in_ready", 32'(bus.in_ready), 32'h4);
    push(2'd2, 4'hA);
    step();
    bus.in_valid = 4'h0;
    chk("fix_out_valid", 32'(bus.out_valid), 1);
    step();
`ifdef MUX_N_ARB_CNT_EN
    chk("cnt_after_fix", 32'(xfer_cnt), 1);
`endif

    // round robin, all channels valid; ptr is still N-1 from reset
    mode         = MODE_RR;
    bus.in_data  = {4'h4, 4'h3, 4'h2, 4'h1};
    bus.in_valid = 4'hF;
    push(2'd0, 4'h1);
    push(2'd1, 4'h2);
    push(2'd2, 4'h3);
    push(2'd3, 4'h4);
    push(2'd0, 4'h1);
    push(2'd1, 4'h2);
    repeat (6) step();

    // sparse requests after a grant to ch1: ch3 then ch1
    bus.in_data  = {4'h7, 4'h0, 4'h5, 4'h0};
    bus.in_valid = 4'b1010;
    #1;
    chk("rr_sparse_ready0", 32'(bus.in_ready), 32'h8);
    push(2'd3, 4'h7);
    push(2'd1, 4'h5);
    step();
    chk("rr_sparse_ready1", 32'(bus.in_ready), 32'h2);
    step();
    bus.in_valid = 4'h0;
    step();
`ifdef MUX_N_ARB_CNT_EN
    chk("cnt_after_rr", 32'(xfer_cnt), 9);
`endif

    // back-pressure: hold ch0 word for 3 cycles, then accept ch1
    mode          = MODE_FIXED;
    sel           = 2'd0;
    bus.in_data   = {4'hD, 4'hC, 4'hB, 4'h9};
    bus.in_valid  = 4'b0001;
    push(2'd0, 4'h9);
    step();
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'hF;
    sel           = 2'd1;
    repeat (3) begin
      #1;
      chk("bp_in_ready", 32'(bus.in_ready), 0);
      chk("bp_out_valid", 32'(bus.out_valid), 1);
      chk("bp_out_data", 32'(bus.out_data), 32'h9);
      chk("bp_out_ch", 32'(bus.out_ch), 0);
      step();
    end
    bus.out_ready = 1'b1;
    push(2'd1, 4'hB);
    #1;
    chk("bp_release_ready", 32'(bus.in_ready), 32'h2);
    step();
    bus.in_valid = 4'h0;
    step();
    step();

    // reset while a word is in flight
    sel           = 2'd3;
    bus.in_valid  = 4'hF;
    bus.out_ready = 1'b0;
    step();
    chk("mid_loaded", 32'(bus.out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(bus.in_ready), 0);
    step();
    chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_out_data", 32'(bus.out_data), 0);
    rst_n         = 1'b1;
    bus.in_valid  = 4'h0;
    bus.out_ready = 1'b1;
    step();

    // ptr back to N-1 after reset, so RR grants ch0 first
    mode         = MODE_RR;
    bus.in_valid = 4'hF;
    #1;
    chk("rr_after_rst_ready", 32'(bus.in_ready), 32'h1);
    push(2'd0, 4'h9);
    step();
    bus.in_valid = 4'h0;
    step();

`ifdef MUX_N_ARB_CNT_EN
    chk("cnt_after_mid_rst", 32'(xfer_cnt), 1);
    mode         = MODE_FIXED;
    sel          = 2'd0;
    bus.in_valid = 4'b0001;
    repeat (4) begin
      push(2'd0, 4'h9);
      step();
    end
    bus.in_valid = 4'h0;
    step();
    chk("cnt_five", 32'(xfer_cnt), 5);
    bus.in_valid = 4'b0001;
    repeat (65530) begin
      push(2'd0, 4'h9);
      step();
    end
    bus.in_valid = 4'h0;
    step();
    chk("cnt_ffff", 32'(xfer_cnt), 32'hFFFF);
    bus.in_valid = 4'b0001;
    push(2'd0, 4'h9);
    step();
    bus.in_valid = 4'h0;
    step();
    chk("cnt_wrap", 32'(xfer_cnt), 0);
`endif

    step();
    chk("queue_empty", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux_n_arb.md
# mux_n_arb

Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshakes on every input and on the output. It is the next generation of the team's fixed 4:1 4-bit combinational mux. It supports two selection modes: externally steered fixed selection, and fair round-robin arbitration among valid channels. It sits between multiple producer streams and a single consumer, and registers the selected word so downstream timing is decoupled.

## Interface
- WIDTH, 4, data bits per channel (≥1)
- N, 4, number of input channels (≥2); SW = $clog2(N) is a derived localparam
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- mode  input  1  0 = fixed select, 1 = round-robin
- sel  input  SW  channel index used in fixed mode
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  N  per-channel valid
- in_ready  output  N  per-channel ready (combinational)
- out_data  output  WIDTH  registered selected word
- out_valid  output  1  registered output valid
- out_ready  input  1  consumer ready
- out_ch  output  SW  index of channel that supplied out_data

## Operation
- Output stage is a single register. load = !out_valid || out_ready.
- Grant selection:
  - Fixed mode: grant = sel, found = in_valid[sel] && sel < N. An out-of-range sel (N not a power of 2) never grants.
  - RR mode: search starts at ptr+1 and wraps modulo N. The first channel with in_valid set is granted; found = |in_valid.
- in_ready[i] = load && found && (grant == i). All other channels see 0. in_ready never depends on in_valid[i] of the same channel beyond the arbitration itself.
- Accept when found && load: out_data ← channel grant, out_ch ← grant, out_valid ← 1.
- When load && !found: out_valid ← 0. out_data and out_ch hold.
- ptr updates to grant only on an accepted transfer in RR mode. Fixed-mode transfers leave ptr unchanged.
- A mode change takes effect at the next arbitration. ptr is retained across mode changes.
- Reset values: out_valid 0, out_data 0, out_ch 0, ptr N-1 (so channel 0 has first RR priority).

## Timing
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: 1 word/cycle. Accept and drain in the same cycle is allowed (out_valid && out_ready && found).
- Back-pressure: with out_valid=1 and out_ready=0, all in_ready = 0 and the output is held stable.
- Reset mid-operation: the in-flight output word is discarded, out_valid drops the cycle after rst_n is sampled low, and in_ready is 0 while rst_n = 0.
- RR fairness: with all N channels continuously valid and out_ready = 1, grants cycle 0,1,…,N-1,0 with no channel starved longer than N-1 transfers.

## Configuration
- MUX_N_ARB_CNT_EN defined: adds output xfer_cnt [15:0].
  - Reset value 0.
  - Increments on every out_valid && out_ready.
  - Wraps from 0xFFFF to 0.
- Undefined: the xfer_cnt port and its counter are absent. All other behaviour is identical.

## Structure
- Shared package mux_pkg: MODE_FIXED = 1'b0, MODE_RR = 1'b1, XFER_CNT_W = 16.
- Sub-module rr_arbiter_n (parameter N): inputs req[N], ptr[SW]; outputs grant[SW], found. Purely combinational rotate-and-priority-encode. ptr storage remains in mux_n_arb.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_ch=0, in_ready=0.
- Fixed mode, WIDTH=4, N=4, sel=2, in_valid=4'b1111, channel 2 = 4'hA, out_ready=1 -> in_ready=4'b0100; next cycle out_data=4'hA, out_ch=2, out_valid=1.
- RR, all valid, channels hold 1,2,3,4, out_ready=1 for 6 cycles -> out_ch sequence 0,1,2,3,0,1 with matching data.
- RR, in_valid=4'b1010 after a grant to ch1 -> next grant ch3, then ch1.
- Back-pressure: out_valid=1, out_ready=0 for 3 cycles -> in_ready=0 and out_data/out_ch stable; the following out_ready=1 cycle accepts a new word.
- With MUX_N_ARB_CNT_EN, 5 output handshakes -> xfer_cnt=5. Preload to 0xFFFF via 65535 transfers, then one more -> xfer_cnt=0.
